// File: rtl/seven_segs_scan.sv
// rtl/seven_segs_scan.sv - time-multiplexed seven-segment scanner with shadow registers and dead time
// Outputs are registered views of the prescaler, the digit index and the shadow data.
module seven_segs_scan #(
    parameter int DIGITS         = 8,
    parameter int PRESCALE       = 50000,
    parameter int DEAD           = 16,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic                  lzb_en,
    output logic [6:0]            seg,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_start
);
    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PCW  = $clog2(PRESCALE);

    localparam logic [6:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [PCW-1:0]      pcnt;
    logic [IDXW-1:0]     idx;
    logic [4*DIGITS-1:0] sh_data;
    logic [DIGITS-1:0]   sh_dp;
    logic [DIGITS-1:0]   sh_en;
    logic                sh_lzb;

    logic [3:0]          nib [DIGITS];
    logic [DIGITS-1:0]   blank;
    logic                hi_zero;
    logic                dark;
    logic [3:0]          cur_nib;
    logic [6:0]          glyph;
    logic [DIGITS-1:0]   an_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
            idx  <= '0;
        end else if (pcnt == PCW'(PRESCALE - 1)) begin
            pcnt <= '0;
            idx  <= (idx == IDXW'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_data <= '0;
            sh_dp   <= '0;
            sh_en   <= '0;
            sh_lzb  <= 1'b0;
        end else if (load) begin
            sh_data <= data;
            sh_dp   <= dp;
            sh_en   <= digit_en;
            sh_lzb  <= lzb_en;
        end
    end

    // Blanking walks down from the most significant digit; digit 0 always shows.
    always_comb begin
        hi_zero = 1'b1;
        blank   = '0;
        for (int i = 0; i < DIGITS; i++) nib[i] = sh_data[4*i +: 4];
        for (int i = DIGITS - 1; i >= 0; i--) begin
            hi_zero  = hi_zero & (nib[i] == 4'h0) & ~sh_dp[i];
            blank[i] = (i > 0) & sh_lzb & hi_zero;
        end
    end

    always_comb begin
        cur_nib = nib[idx];
        dark    = (int'(pcnt) < DEAD) | ~sh_en[idx] | blank[idx];
        an_sel  = '0;
        an_sel[idx] = 1'b1;
        case (cur_nib)      // g..a bit order
            4'h0: glyph = 7'b0111111;
            4'h1: glyph = 7'b0000110;
            4'h2: glyph = 7'b1011011;
            4'h3: glyph = 7'b1001111;
            4'h4: glyph = 7'b1100110;
            4'h5: glyph = 7'b1101101;
            4'h6: glyph = 7'b1111101;
            4'h7: glyph = 7'b0000111;
            4'h8: glyph = 7'b1111111;
            4'h9: glyph = 7'b1100111;
            4'hA: glyph = 7'b1110111;
            4'hB: glyph = 7'b1111100;
            4'hC: glyph = 7'b0111001;
            4'hD: glyph = 7'b1011110;
            4'hE: glyph = 7'b1111001;
            default: glyph = 7'b1110001;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg         <= SEG_OFF;
            dp_out      <= DP_OFF;
            an          <= AN_OFF;
            frame_start <= 1'b0;
        end else begin
            frame_start <= (idx == '0) && (pcnt == '0);
            if (dark) begin
                seg    <= SEG_OFF;
                dp_out <= DP_OFF;
                an     <= AN_OFF;
            end else begin
                seg    <= glyph ^ SEG_OFF;
                dp_out <= sh_dp[idx] ^ DP_OFF;
                an     <= an_sel ^ AN_OFF;
            end
        end
    end
endmodule
